// File: rtl/regfile_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg: shared widths, source ids and write-request type for the
// register-file writeback arbiter.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if: ALU and load writeback handshakes into the arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_data_i;

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output ld_valid_i,  ld_addr_i,  ld_data_i,
    input  alu_ready_o, ld_ready_o
  );

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  ld_valid_i,  ld_addr_i,  ld_data_i,
    output alu_ready_o, ld_ready_o
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2: two-request round-robin arbiter; pointer moves to the loser only
// when both requests collide.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import regfile_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_req_alu,
  input  wire logic i_req_ld,
  output logic      o_gnt_alu,
  output logic      o_gnt_ld,
  output logic      o_conflict
);

  wb_src_t r_prio;
  wb_src_t w_prio_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_prio <= SRC_ALU;
    else     r_prio <= w_prio_nxt;
  end

  // No grants while in reset so a waiting source is never accepted early.
  always_comb begin
    o_gnt_alu  = 1'b0;
    o_gnt_ld   = 1'b0;
    o_conflict = 1'b0;
    w_prio_nxt = r_prio;
    if (!rst) begin
      if (i_req_alu && i_req_ld) begin
        o_conflict = 1'b1;
        if (r_prio == SRC_ALU) begin
          o_gnt_alu  = 1'b1;
          w_prio_nxt = SRC_LD;
        end else begin
          o_gnt_ld   = 1'b1;
          w_prio_nxt = SRC_ALU;
        end
      end else if (i_req_alu) begin
        o_gnt_alu = 1'b1;
      end else if (i_req_ld) begin
        o_gnt_ld = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter: shares the register-file write port between ALU and
// load writeback, with a staged write, read bypass and contention counter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  regfile_wb_arbiter_if.slave    bus,
  output logic                   rf_we_o,
  output logic [ADDR_W-1:0]      rf_wr_addr_o,
  output logic [DATA_W-1:0]      rf_wr_data_o,
  input  wire logic [ADDR_W-1:0] rd_addr0_i,
  input  wire logic [ADDR_W-1:0] rd_addr1_i,
  input  wire logic [DATA_W-1:0] rf_rd_data0_i,
  input  wire logic [DATA_W-1:0] rf_rd_data1_i,
  output logic [DATA_W-1:0]      rd_data0_o,
  output logic [DATA_W-1:0]      rd_data1_o,
  output logic [CNT_W-1:0]       conflict_cnt_o
);

  logic              w_gnt_alu;
  logic              w_gnt_ld;
  logic              w_conflict;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req_alu  (bus.alu_valid_i),
    .i_req_ld   (bus.ld_valid_i),
    .o_gnt_alu  (w_gnt_alu),
    .o_gnt_ld   (w_gnt_ld),
    .o_conflict (w_conflict)
  );

  assign bus.alu_ready_o = w_gnt_alu;
  assign bus.ld_ready_o  = w_gnt_ld;

  // Writes to $0 are consumed but never enable the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_gnt_alu) begin
      r_we   <= |bus.alu_addr_i;
      r_addr <= bus.alu_addr_i;
      r_data <= bus.alu_data_i;
    end else if (w_gnt_ld) begin
      r_we   <= |bus.ld_addr_i;
      r_addr <= bus.ld_addr_i;
      r_data <= bus.ld_data_i;
    end else begin
      r_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            r_cnt <= '0;
    else if (w_conflict && ~&r_cnt)     r_cnt <= r_cnt + 1'b1;
  end

  // Gating with rst keeps a staged write from landing at the reset edge.
  assign rf_we_o        = r_we & ~rst;
  assign rf_wr_addr_o   = r_addr;
  assign rf_wr_data_o   = r_data;
  assign conflict_cnt_o = r_cnt;

  assign rd_data0_o = (rf_we_o && (r_addr == rd_addr0_i)) ? r_data : rf_rd_data0_i;
  assign rd_data1_o = (rf_we_o && (r_addr == rd_addr1_i)) ? r_data : rf_rd_data1_i;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter: directed bench with a behavioural register file.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rf_we;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [AW-1:0] rd_addr0, rd_addr1;
  logic [DW-1:0] rf_rd_data0, rf_rd_data1;
  logic [DW-1:0] rd_data0, rd_data1;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:31] = '{7: 32'h1111_1111, default: 32'h0};

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .rf_we_o        (rf_we),
    .rf_wr_addr_o   (rf_wr_addr),
    .rf_wr_data_o   (rf_wr_data),
    .rd_addr0_i     (rd_addr0),
    .rd_addr1_i     (rd_addr1),
    .rf_rd_data0_i  (rf_rd_data0),
    .rf_rd_data1_i  (rf_rd_data1),
    .rd_data0_o     (rd_data0),
    .rd_data1_o     (rd_data1),
    .conflict_cnt_o (cnt)
  );

  always @(posedge clk) begin
    if (rf_we && rf_wr_addr != 5'd0) mem[rf_wr_addr] <= rf_wr_data;
  end
  assign rf_rd_data0 = mem[rd_addr0];
  assign rf_rd_data1 = mem[rd_addr1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd5; bus.alu_data_i = 32'h1234;
    tick(); tick();
    checks++; if (bus.alu_ready_o !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got=%b exp=0", bus.alu_ready_o); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", rf_we); end
    checks++; if (rf_wr_addr !== 5'd0 || rf_wr_data !== 32'd0) begin errors++; $display("FAIL rst_stage got=%0d/%h exp=0/0", rf_wr_addr, rf_wr_data); end
    checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
    rst = 1'b0;
    #1;
    checks++; if (bus.alu_ready_o !== 1'b1) begin errors++; $display("FAIL held_alu_ready got=%b exp=1", bus.alu_ready_o); end
    tick();
    bus.alu_valid_i = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd5) begin errors++; $display("FAIL staged_r5 got=%b/%0d exp=1/5", rf_we, rf_wr_addr); end
    rst = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we got=%b exp=0", rf_we); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (mem[5] === 32'h1234) begin errors++; $display("FAIL rst_discard r5 got=%h exp=!00001234", mem[5]); end
    checks++; if (rf_we !== 1'b0 || rf_wr_addr !== 5'd0) begin errors++; $display("FAIL post_rst_stage got=%b/%0d exp=0/0", rf_we, rf_wr_addr); end
  endtask

  task automatic test_contention();
    int ai = 0;
    int li = 0;
    logic [AW-1:0] exp_addr [4] = '{5'd1, 5'd9, 5'd2, 5'd10};
    logic exp_alu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.alu_valid_i = 1'b1;
    bus.ld_valid_i  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.alu_addr_i = AW'(1 + ai); bus.alu_data_i = 32'hA000_0000 + 32'(ai);
      bus.ld_addr_i  = AW'(9 + li); bus.ld_data_i  = 32'hB000_0000 + 32'(li);
      #1;
      checks++; if (bus.alu_ready_o !== exp_alu[c] || bus.ld_ready_o !== !exp_alu[c]) begin
        errors++; $display("FAIL cont_grant[%0d] got=%b%b exp=%b%b", c, bus.alu_ready_o, bus.ld_ready_o, exp_alu[c], !exp_alu[c]);
      end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_wr_addr !== exp_addr[c]) begin
        errors++; $display("FAIL cont_addr[%0d] got=%b/%0d exp=1/%0d", c, rf_we, rf_wr_addr, exp_addr[c]);
      end
      if (exp_alu[c]) ai++; else li++;
    end
    bus.alu_valid_i = 1'b0;
    bus.ld_valid_i  = 1'b0;
    checks++; if (cnt !== 4'd4) begin errors++; $display("FAIL cont_cnt got=%0d exp=4", cnt); end
    tick();
  endtask

  task automatic test_zero_write();
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd0; bus.alu_data_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.alu_ready_o !== 1'b1) begin errors++; $display("FAIL r0_ready got=%b exp=1", bus.alu_ready_o); end
    tick();
    bus.alu_valid_i = 1'b0;
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got=%b exp=0", rf_we); end
    checks++; if (rd_data0 !== 32'd0 || rd_data1 !== 32'd0) begin errors++; $display("FAIL r0_read got=%h/%h exp=0/0", rd_data0, rd_data1); end
    tick();
  endtask

  task automatic test_bypass();
    bus.ld_valid_i = 1'b1; bus.ld_addr_i = 5'd7; bus.ld_data_i = 32'hCAFE_F00D;
    #1;
    checks++; if (bus.ld_ready_o !== 1'b1) begin errors++; $display("FAIL byp_ready got=%b exp=1", bus.ld_ready_o); end
    tick();
    bus.ld_valid_i = 1'b0;
    rd_addr0 = 5'd7; rd_addr1 = 5'd7;
    #1;
    checks++; if (rf_rd_data0 !== 32'h1111_1111) begin errors++; $display("FAIL byp_raw got=%h exp=11111111", rf_rd_data0); end
    checks++; if (rd_data0 !== 32'hCAFE_F00D || rd_data1 !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL byp_hit got=%h/%h exp=cafef00d/cafef00d", rd_data0, rd_data1);
    end
    tick();
    checks++; if (mem[7] !== 32'hCAFE_F00D || rd_data0 !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL byp_commit got=%h/%h exp=cafef00d", mem[7], rd_data0);
    end
  endtask

  task automatic test_ld_only();
    logic [AW-1:0] la [3] = '{5'd14, 5'd20, 5'd21};
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd13; bus.alu_data_i = 32'h13;
    bus.ld_valid_i  = 1'b1; bus.ld_addr_i  = la[0]; bus.ld_data_i  = 32'h14;
    #1;
    checks++; if (bus.alu_ready_o !== 1'b1) begin errors++; $display("FAIL ldo_prime got=%b exp=1", bus.alu_ready_o); end
    tick();
    bus.alu_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.ld_addr_i = la[c]; bus.ld_data_i = 32'(la[c]);
      #1;
      checks++; if (bus.ld_ready_o !== 1'b1) begin errors++; $display("FAIL ldo_ready[%0d] got=%b exp=1", c, bus.ld_ready_o); end
      tick();
      checks++; if (rf_wr_addr !== la[c]) begin errors++; $display("FAIL ldo_addr[%0d] got=%0d exp=%0d", c, rf_wr_addr, la[c]); end
    end
    checks++; if (cnt !== 4'd5) begin errors++; $display("FAIL ldo_cnt got=%0d exp=5", cnt); end
    bus.alu_valid_i = 1'b1;
    #1;
    checks++; if (bus.ld_ready_o !== 1'b1 || bus.alu_ready_o !== 1'b0) begin
      errors++; $display("FAIL ldo_prio got=%b%b exp=01", bus.alu_ready_o, bus.ld_ready_o);
    end
    tick();
    bus.alu_valid_i = 1'b0; bus.ld_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd3; bus.alu_data_i = 32'h3;
    bus.ld_valid_i  = 1'b1; bus.ld_addr_i  = 5'd4; bus.ld_data_i  = 32'h4;
    for (int c = 0; c < 14; c++) tick();
    checks++; if (cnt !== 4'd14) begin errors++; $display("FAIL sat_14 got=%0d exp=14", cnt); end
    tick();
    checks++; if (cnt !== 4'd15) begin errors++; $display("FAIL sat_15 got=%0d exp=15", cnt); end
    tick(); tick();
    checks++; if (cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", cnt); end
    bus.alu_valid_i = 1'b0; bus.ld_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.alu_valid_i = 1'b0; bus.alu_addr_i = '0; bus.alu_data_i = '0;
    bus.ld_valid_i  = 1'b0; bus.ld_addr_i  = '0; bus.ld_data_i  = '0;
    rd_addr0 = '0; rd_addr1 = '0;
    test_reset();
    test_contention();
    test_zero_write();
    test_bypass();
    test_ld_only();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
